demux1_2_stream: RTL and testbench

Registered, flow-controlled 1:2 demultiplexer: the sequential successor to the combinational 1:2 demux. Each accepted input beat carries a select bit S; the beat is steered into the Y1 channel (S=0) or the Y2 channel (S=1). Each channel has its own small FIFO and valid/ready output, so one stalled consumer does not drop data. The block sits between a single producer and two independent consumers.

---
 rtl/demux_pkg.sv | 22 ++
 rtl/chan_fifo.sv | 72 +++++++
 rtl/demux1_2_stream.sv | 97 +++++++++
 tb/tb_demux1_2_stream.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the registered 1:2 stream demux.
//   CNT_W        width of the per-channel delivered-beat counters
//   CH_Y1/CH_Y2  select values that steer a beat to channel 1 / channel 2
//   clog2()      ceiling log2, used to size FIFO pointers and occupancy counts
package demux_pkg;

    localparam int   CNT_W = 16;
    localparam logic CH_Y1 = 1'b0;
    localparam logic CH_Y2 = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// chan_fifo: one output channel of the demux, a small circular FIFO whose
// head entry is presented directly from the storage registers.
//   CLK, RST  clock and synchronous active-high reset
//   push, din write din behind the existing entries (ignored when full)
//   pop       remove the head entry (ignored when empty)
//   dout      head entry; reads 0 after reset
//   valid     FIFO is non-empty
//   count     occupancy, 0..DEPTH
module chan_fifo
    import demux_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEPTH   = 2,
    localparam int PTR_W   = clog2(DEPTH),
    localparam int COUNT_W = clog2(DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               push,
    input  logic [W-1:0]       din,
    input  logic               pop,
    output logic [W-1:0]       dout,
    output logic               valid,
    output logic [COUNT_W-1:0] count
);

    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [COUNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Local guards keep the pointers consistent even if a caller pushes into
    // a full FIFO or pops an empty one.
    assign w_push = push && (r_count != CNT_FULL);
    assign w_pop  = pop  && (r_count != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // Storage is cleared so the head never reads as X after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);
    assign count = r_count;

endmodule

// File: rtl/demux1_2_stream.sv
// demux1_2_stream: registered, flow-controlled 1:2 demultiplexer. Each accepted
// beat is queued in the channel chosen by S; each channel drains independently.
//   CLK, RST             clock and synchronous active-high reset
//   A, S                 input beat and its channel select (0 -> Y1, 1 -> Y2)
//   A_VALID, A_READY     input handshake; A_READY depends only on S and counts
//   Y1_DATA/VALID/READY  channel 1 output handshake
//   Y2_DATA/VALID/READY  channel 2 output handshake
//   CNT1, CNT2           beats delivered per channel, wrapping at 2^16
module demux1_2_stream
    import demux_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     A,
    input  logic             S,
    input  logic             A_VALID,
    output logic             A_READY,
    output logic [W-1:0]     Y1_DATA,
    output logic             Y1_VALID,
    input  logic             Y1_READY,
    output logic [W-1:0]     Y2_DATA,
    output logic             Y2_VALID,
    input  logic             Y2_READY,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2
);

    localparam int                 COUNT_W  = clog2(DEPTH + 1);
    localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(DEPTH);

    logic [COUNT_W-1:0] w_count1;
    logic [COUNT_W-1:0] w_count2;
    logic [COUNT_W-1:0] w_sel_count;
    logic               w_push;
    logic               w_push1;
    logic               w_push2;
    logic               w_pop1;
    logic               w_pop2;

    logic [CNT_W-1:0]   r_cnt1;
    logic [CNT_W-1:0]   r_cnt2;

    // Ready looks only at the addressed channel's registered occupancy, so a
    // full target stalls the input even when the other channel has room, and
    // a same-cycle pop never makes room for a push.
    assign w_sel_count = (S == CH_Y2) ? w_count2 : w_count1;
    assign A_READY     = (w_sel_count < CNT_FULL);

    assign w_push  = A_VALID && A_READY;
    assign w_push1 = w_push && (S == CH_Y1);
    assign w_push2 = w_push && (S == CH_Y2);
    assign w_pop1  = Y1_VALID && Y1_READY;
    assign w_pop2  = Y2_VALID && Y2_READY;

    chan_fifo #(.W(W), .DEPTH(DEPTH)) u_chan_y1 (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_push1),
        .din   (A),
        .pop   (w_pop1),
        .dout  (Y1_DATA),
        .valid (Y1_VALID),
        .count (w_count1)
    );

    chan_fifo #(.W(W), .DEPTH(DEPTH)) u_chan_y2 (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_push2),
        .din   (A),
        .pop   (w_pop2),
        .dout  (Y2_DATA),
        .valid (Y2_VALID),
        .count (w_count2)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            if (w_pop1) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
            if (w_pop2) begin
                r_cnt2 <= r_cnt2 + 1'b1;
            end
        end
    end

    assign CNT1 = r_cnt1;
    assign CNT2 = r_cnt2;

endmodule

// File: tb/tb_demux1_2_stream.sv
module tb_demux1_2_stream;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  A;
    logic        S;
    logic        A_VALID;
    logic        A_READY;
    logic [7:0]  Y1_DATA;
    logic        Y1_VALID;
    logic        Y1_READY;
    logic [7:0]  Y2_DATA;
    logic        Y2_VALID;
    logic        Y2_READY;
    logic [15:0] CNT1;
    logic [15:0] CNT2;

    int n_checks = 0;
    int n_fail   = 0;

    demux1_2_stream #(.W(8), .DEPTH(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .A        (A),
        .S        (S),
        .A_VALID  (A_VALID),
        .A_READY  (A_READY),
        .Y1_DATA  (Y1_DATA),
        .Y1_VALID (Y1_VALID),
        .Y1_READY (Y1_READY),
        .Y2_DATA  (Y2_DATA),
        .Y2_VALID (Y2_VALID),
        .Y2_READY (Y2_READY),
        .CNT1     (CNT1),
        .CNT2     (CNT2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one input beat, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [7:0] a, input logic s);
        A_VALID = v;
        A       = a;
        S       = s;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        A_VALID = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        int idx, n1, n2, cyc;

        RST = 1'b1; A = '0; S = 1'b0; A_VALID = 1'b0;
        Y1_READY = 1'b0; Y2_READY = 1'b0;

        // Reset then idle
        do_reset();
        chk("rst_y1_valid", 32'(Y1_VALID), 0);
        chk("rst_y2_valid", 32'(Y2_VALID), 0);
        chk("rst_y1_data",  32'(Y1_DATA), 0);
        chk("rst_y2_data",  32'(Y2_DATA), 0);
        chk("rst_cnt1",     32'(CNT1), 0);
        chk("rst_cnt2",     32'(CNT2), 0);
        chk("rst_a_ready",  32'(A_READY), 1);

        // Steering
        Y1_READY = 1'b1; Y2_READY = 1'b1;
        drive(1'b1, 8'h11, 1'b0);
        chk("steer_rdy0", 32'(A_READY), 1);
        tick();
        drive(1'b1, 8'h22, 1'b1);
        chk("steer_y1_valid", 32'(Y1_VALID), 1);
        chk("steer_y1_data",  32'(Y1_DATA), 32'h11);
        chk("steer_y2_empty", 32'(Y2_VALID), 0);
        chk("steer_rdy1",     32'(A_READY), 1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("steer_y2_valid", 32'(Y2_VALID), 1);
        chk("steer_y2_data",  32'(Y2_DATA), 32'h22);
        chk("steer_y1_gone",  32'(Y1_VALID), 0);
        chk("steer_cnt1",     32'(CNT1), 1);
        tick();
        chk("steer_y2_gone",  32'(Y2_VALID), 0);
        chk("steer_cnt2",     32'(CNT2), 1);

        // Full channel blocking
        Y1_READY = 1'b0; Y2_READY = 1'b1;
        drive(1'b1, 8'h01, 1'b0);
        tick();
        drive(1'b1, 8'h02, 1'b0);
        chk("full_rdy_2nd", 32'(A_READY), 1);
        tick();
        drive(1'b1, 8'h99, 1'b0);
        chk("full_block", 32'(A_READY), 0);
        tick();
        drive(1'b1, 8'h03, 1'b1);
        chk("full_other_ok", 32'(A_READY), 1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("full_y2_data", 32'(Y2_DATA), 32'h03);
        chk("full_y1_head", 32'(Y1_DATA), 32'h01);
        Y1_READY = 1'b1;
        tick();
        chk("full_y1_second", 32'(Y1_DATA), 32'h02);
        chk("full_y1_valid",  32'(Y1_VALID), 1);
        chk("full_y2_empty",  32'(Y2_VALID), 0);
        tick();
        chk("full_y1_drained", 32'(Y1_VALID), 0);
        chk("full_cnt1", 32'(CNT1), 3);
        chk("full_cnt2", 32'(CNT2), 2);

        // Simultaneous push and pop on a full channel
        Y1_READY = 1'b0;
        drive(1'b1, 8'h41, 1'b0);
        tick();
        drive(1'b1, 8'h42, 1'b0);
        tick();
        Y1_READY = 1'b1;
        drive(1'b1, 8'h43, 1'b0);
        chk("pp_no_passthru", 32'(A_READY), 0);
        chk("pp_head0", 32'(Y1_DATA), 32'h41);
        tick();
        chk("pp_rdy_next", 32'(A_READY), 1);
        chk("pp_head1", 32'(Y1_DATA), 32'h42);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("pp_head2", 32'(Y1_DATA), 32'h43);
        chk("pp_valid2", 32'(Y1_VALID), 1);
        tick();
        chk("pp_drained", 32'(Y1_VALID), 0);
        chk("pp_cnt1", 32'(CNT1), 6);

        // Wrap-around with random stalls, from a clean reset
        do_reset();
        idx = 0; n1 = 0; n2 = 0; cyc = 0;
        while ((idx < 40 || n1 < 20 || n2 < 20) && cyc < 2000) begin
            A_VALID  = (idx < 40);
            A        = 8'(idx);
            S        = idx[0];
            Y1_READY = ($urandom_range(0, 3) != 0);
            Y2_READY = ($urandom_range(0, 3) != 0);
            #1;
            if (Y1_VALID && Y1_READY) begin
                chk("wrap_y1", 32'(Y1_DATA), 32'(2 * n1));
                n1++;
            end
            if (Y2_VALID && Y2_READY) begin
                chk("wrap_y2", 32'(Y2_DATA), 32'(2 * n2 + 1));
                n2++;
            end
            if (A_VALID && A_READY) idx++;
            tick();
            cyc++;
        end
        A_VALID = 1'b0;
        chk("wrap_timeout", 32'(cyc < 2000), 1);
        chk("wrap_n1", 32'(n1), 20);
        chk("wrap_n2", 32'(n2), 20);
        chk("wrap_cnt1", 32'(CNT1), 20);
        chk("wrap_cnt2", 32'(CNT2), 20);
        #1;
        chk("wrap_y1_idle", 32'(Y1_VALID), 0);
        chk("wrap_y2_idle", 32'(Y2_VALID), 0);

        // Mid-operation reset
        Y1_READY = 1'b0; Y2_READY = 1'b0;
        drive(1'b1, 8'h51, 1'b0); tick();
        drive(1'b1, 8'h52, 1'b0); tick();
        drive(1'b1, 8'h53, 1'b1); tick();
        drive(1'b1, 8'h54, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("mrst_pre_y1", 32'(Y1_VALID), 1);
        chk("mrst_pre_y2", 32'(Y2_VALID), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("mrst_y1_valid", 32'(Y1_VALID), 0);
        chk("mrst_y2_valid", 32'(Y2_VALID), 0);
        chk("mrst_cnt1", 32'(CNT1), 0);
        chk("mrst_cnt2", 32'(CNT2), 0);
        chk("mrst_rdy_s0", 32'(A_READY), 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("mrst_rdy_s1", 32'(A_READY), 1);
        Y1_READY = 1'b1; Y2_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst_no_stale1", 32'(Y1_VALID), 0);
            chk("mrst_no_stale2", 32'(Y2_VALID), 0);
        end
        Y1_READY = 1'b0;
        drive(1'b1, 8'h60, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("mrst_fresh_valid", 32'(Y1_VALID), 1);
        chk("mrst_fresh_data",  32'(Y1_DATA), 32'h60);
        chk("mrst_cnt_still0",  32'(CNT1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
